// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter.
// Arbiter states, grant codes and the read byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } grant_e;

  // Sliced to the byte-enable width at the use site.
  localparam logic [127:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch waits.
// Ports: clk_i, rst_i (async, active-high), inc, clr, sat (count == MAX).
module arb_streak_counter #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAX));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetch and MEM data access.
// Data side has priority; all outputs are registered.
// Ports: clk_i, rst_i (async, active-high); ireq_*/iresp_* fetch side;
//   dreq_*/dresp_* data side; mem_* backing-memory request/ack.
// Optional macro MEM_ARB_STARVE_GUARD_EN: after MAX_D_STREAK data
//   grants with a fetch waiting, the next contested grant goes to IF.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ireq_valid_i,
  input  logic [ADDR_W-1:0]   ireq_addr_i,
  output logic                iresp_ready_o,
  output logic [DATA_W-1:0]   iresp_data_o,
  input  logic                dreq_valid_i,
  input  logic                dreq_we_i,
  input  logic [ADDR_W-1:0]   dreq_addr_i,
  input  logic [DATA_W-1:0]   dreq_wdata_i,
  input  logic [DATA_W/8-1:0] dreq_be_i,
  output logic                dresp_ready_o,
  output logic [DATA_W-1:0]   dresp_data_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  grant_e     gnt;

  logic              req_d, we_d, irdy_d, drdy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, idata_d, ddata_d;
  logic [BE_W-1:0]   be_d;

  // A requester still seeing its ready pulse has not yet had a chance
  // to update valid/addr, so it must not be served twice.
  logic d_ok, i_ok, i_force;
  assign d_ok = dreq_valid_i && !dresp_ready_o;
  assign i_ok = ireq_valid_i && !iresp_ready_o;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic sat, s_inc, s_clr;
  assign i_force = sat && d_ok && i_ok;
  assign s_inc   = (gnt == GNT_D) && ireq_valid_i;
  assign s_clr   = (gnt == GNT_I) ||
                   ((gnt == GNT_D) && !ireq_valid_i);

  arb_streak_counter #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (s_inc),
    .clr   (s_clr),
    .sat   (sat)
  );
`else
  assign i_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    req_d   = mem_req_o;
    we_d    = mem_we_o;
    addr_d  = mem_addr_o;
    wdata_d = mem_wdata_o;
    be_d    = mem_be_o;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    idata_d = iresp_data_o;
    ddata_d = dresp_data_o;
    unique case (state_q)
      IDLE: begin
        if (i_force)   gnt = GNT_I;
        else if (d_ok) gnt = GNT_D;
        else if (i_ok) gnt = GNT_I;
        if (gnt == GNT_D) begin
          state_d = BUSY_D;
          req_d   = 1'b1;
          we_d    = dreq_we_i;
          addr_d  = dreq_addr_i;
          wdata_d = dreq_wdata_i;
          be_d    = dreq_we_i ? dreq_be_i
                              : BE_ALL_ONES[BE_W-1:0];
        end else if (gnt == GNT_I) begin
          state_d = BUSY_I;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = ireq_addr_i;
          wdata_d = '0;
          be_d    = BE_ALL_ONES[BE_W-1:0];
        end
      end
      BUSY_I: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          irdy_d  = 1'b1;
          idata_d = mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          drdy_d  = 1'b1;
          if (!mem_we_o) ddata_d = mem_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_be_o      <= '0;
      iresp_ready_o <= 1'b0;
      dresp_ready_o <= 1'b0;
      iresp_data_o  <= '0;
      dresp_data_o  <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_o     <= req_d;
      mem_we_o      <= we_d;
      mem_addr_o    <= addr_d;
      mem_wdata_o   <= wdata_d;
      mem_be_o      <= be_d;
      iresp_ready_o <= irdy_d;
      dresp_ready_o <= drdy_d;
      iresp_data_o  <= idata_d;
      dresp_data_o  <= ddata_d;
    end
  end

endmodule
